// File: rtl/rv_pkg.sv
// Shared RISC-V load/store encodings and the LSU state type.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Unsigned sub-word variants only make sense for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Word-wide req/ack data-memory port between the LSU (master) and memory (slave).
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store replication, load extraction.
// LSU_MISALIGN_TRAP_EN adds the misalign_o flag; otherwise offsets are forced aligned.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_val_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  logic        is_half;
  logic        is_word;
  logic        sign_ext;
  logic [1:0]  eff_off;
  logic [15:0] lane;

  assign is_half  = (funct3_i[1:0] == 2'b01);
  assign is_word  = (funct3_i[1:0] == 2'b10);
  assign sign_ext = !funct3_i[2];

  // Halves drop addr[0], words drop addr[1:0]; a trapping access never reaches memory.
  assign eff_off = is_word ? 2'b00 : (is_half ? {off_i[1], 1'b0} : off_i);
  assign lane    = 16'(mem_rdata_i >> {eff_off, 3'b000});

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned and no latch is inferred.
    be_o       = 4'b0000;
    wdata_o    = store_data_i;
    load_val_o = mem_rdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o       = 4'b0001 << eff_off;
        wdata_o    = {4{store_data_i[7:0]}};
        load_val_o = {{24{lane[7] & sign_ext}}, lane[7:0]};
      end
      2'b01: begin
        be_o       = 4'b0011 << eff_off;
        wdata_o    = {2{store_data_i[15:0]}};
        load_val_o = {{16{lane[15] & sign_ext}}, lane[15:0]};
      end
      2'b10: begin
        be_o = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o = (is_half & off_i[0]) | (is_word & (|off_i));
`endif

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one req/ack memory transaction per accepted LOAD/STORE.
// LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into err+misalign with no memory access.
module lsu_mem_ctrl
  import rv_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] load_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  lsu_mem_ctrl_if.master mem
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t        state_q;
  logic              busy_q, done_q, err_q, wb_en_q;
  logic [4:0]        wb_rd_q, rd_q;
  logic [31:0]       load_data_q, lres_q;
  logic              we_q, fail_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              misalign_q, mis_pend_q;
  logic              al_mis;
`endif

  logic        idle, is_store, accept, legal, trap;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        addr_hi_unused;

  assign addr_hi_unused = ^addr[31:ADDR_W];

  assign idle     = (state_q == IDLE);
  assign is_store = (opcode == OPC_STORE);
  assign accept   = start && !busy_q && (opcode == OPC_LOAD || is_store);
  assign legal    = f3_legal(is_store, funct3);

  // The aligner serves the incoming request in IDLE and the captured one while waiting for ack.
  assign al_f3  = idle ? funct3 : funct3_q;
  assign al_off = idle ? addr[1:0] : off_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = al_mis;
`else
  assign trap = 1'b0;
`endif

  lsu_align u_align (
    .funct3_i    (al_f3),
    .off_i       (al_off),
    .store_data_i(store_data),
    .mem_rdata_i (mem.mem_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .load_val_o  (al_load)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o  (al_mis)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      load_data_q <= '0;
      lres_q      <= '0;
      we_q        <= 1'b0;
      fail_q      <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
      mis_pend_q  <= 1'b0;
`endif
    end else begin
      // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wb_en_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      // busy stays up through the done cycle, which enforces the 4-cycle start spacing.
      if (done_q) busy_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q   <= 1'b1;
            we_q     <= is_store;
            funct3_q <= funct3;
            off_q    <= addr[1:0];
            rd_q     <= rd;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_pend_q <= trap && legal;
`endif
            if (!legal || trap) begin
              state_q <= RESP;
              fail_q  <= 1'b1;
            end else begin
              state_q     <= REQ;
              fail_q      <= 1'b0;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= al_be;
              mem_wdata_q <= al_wdata;
            end
          end
        end

        REQ: begin
          if (mem.mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (!we_q) lres_q <= al_load;
          end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            fail_q    <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        RESP: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          err_q   <= fail_q;
          wb_en_q <= !we_q && !fail_q && (rd_q != 5'd0);
          wb_rd_q <= rd_q;
          if (!we_q && !fail_q) load_data_q <= lres_q;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_q <= mis_pend_q;
`endif
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign wb_en         = wb_en_q;
  assign wb_rd         = wb_rd_q;
  assign load_data     = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign      = misalign_q;
`endif
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_lsu_mem_ctrl;
  import rv_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 255;
  localparam int BUDGET  = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, err, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) mem_if ();

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .funct3    (funct3),
    .addr      (addr),
    .store_data(store_data),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .load_data (load_data),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign  (misalign),
`endif
    .mem       (mem_if)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ld = '0;

  // Results of the most recent run_txn
  int          r_done_cyc, r_req_cycles, r_req_first, r_extra_done, r_extra_req;
  bit          r_stable, r_stray;
  logic [15:0] r_addr;
  logic [3:0]  r_be;
  logic        r_we, r_err, r_wb_en, r_mis;
  logic [31:0] r_wdata, r_load;
  logic [4:0]  r_wb_rd;

  // Reference model: size/offset arithmetic straight from the access rules.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rdat,
                                output bit ill, output bit mis, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int size, off;
    logic [31:0] mask, raw;
    ill = 1'b0;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default: begin size = 4; ill = 1'b1; end
    endcase
    if (st && f3[2]) ill = 1'b1;
    mis  = !ill && (int'(a % 4) % size != 0);
    off  = int'(a % 4) - (int'(a % 4) % size);
    be   = 4'(((1 << size) - 1) << off);
    wd   = (size == 1) ? 32'(sd[7:0]) * 32'h01010101 :
           (size == 2) ? 32'(sd[15:0]) * 32'h00010001 : sd;
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    raw  = (rdat >> (8 * off)) & mask;
    ld   = raw;
    if (!f3[2] && size < 4 && raw[8*size-1]) ld = raw | ~mask;
  endfunction

  // Issue one start at cycle 0 and act as memory; ack_d = req cycles until ack (0 = never).
  // extra_k pulses a second start during busy; it must be dropped.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rdv, input logic [31:0] rdat,
                         input int ack_d, input int extra_k);
    r_done_cyc = -1; r_req_cycles = 0; r_req_first = -1; r_stable = 1'b1; r_stray = 1'b0;
    r_extra_done = 0; r_extra_req = 0; r_mis = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = sd; rd = rdv;
    mem_if.mem_ack = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = (k == extra_k);
      if (k == extra_k) begin
        opcode = OPC_LOAD; funct3 = F3_W; addr = $urandom; rd = 5'd7;
      end
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = $urandom;
      if (mem_if.mem_req) begin
        r_req_cycles++;
        if (r_req_first < 0) begin
          r_req_first = k; r_addr = mem_if.mem_addr; r_be = mem_if.mem_be;
          r_we = mem_if.mem_we; r_wdata = mem_if.mem_wdata;
        end else if ({mem_if.mem_addr, mem_if.mem_be, mem_if.mem_we, mem_if.mem_wdata} !==
                     {r_addr, r_be, r_we, r_wdata}) begin
          r_stable = 1'b0;
        end
        if (r_req_cycles == ack_d) begin
          mem_if.mem_ack = 1'b1; mem_if.mem_rdata = rdat;
        end
      end else begin
        mem_if.mem_ack = 1'($urandom_range(0, 1));
      end
      if (err && !done) r_stray = 1'b1;
      if (done) begin
        r_done_cyc = k; r_err = err; r_wb_en = wb_en; r_wb_rd = wb_rd; r_load = load_data;
`ifdef LSU_MISALIGN_TRAP_EN
        r_mis = misalign;
`endif
        break;
      end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      start = 1'b0; mem_if.mem_ack = 1'b0;
      if (done) r_extra_done++;
      if (mem_if.mem_req) r_extra_req++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, err, wb_en, wb_rd, load_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b wb_en=%b wb_rd=%0d ld=%h, want all 0",
               busy, done, err, wb_en, wb_rd, load_data);
    end
    checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got req=%b we=%b addr=%h be=%b wdata=%h, want all 0",
               mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
`endif
  endtask

  task automatic test_load_word;
    run_txn(OPC_LOAD, F3_W, 32'h0000_0104, 32'h0, 5'd5, 32'hDEAD_BEEF, 1, 3);
    exp_ld = 32'hDEAD_BEEF;
    checks++;
    if (r_addr !== 16'h0104 || r_be !== 4'b1111 || r_we !== 1'b0) begin
      errors++; $display("FAIL lw_bus: got addr=%h be=%b we=%b, want 0104 1111 0", r_addr, r_be, r_we);
    end
    checks++;
    if (r_done_cyc !== 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", r_done_cyc); end
    checks++;
    if (r_load !== exp_ld || r_wb_en !== 1'b1 || r_wb_rd !== 5'd5 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_result: got ld=%h wb_en=%b wb_rd=%0d err=%b, want deadbeef 1 5 0",
               r_load, r_wb_en, r_wb_rd, r_err);
    end
    checks++;
    if (r_extra_done !== 0 || r_extra_req !== 0) begin
      errors++;
      $display("FAIL lw_spacing: start in done cycle gave extra done=%0d req=%0d, want 0 0",
               r_extra_done, r_extra_req);
    end
  endtask

  task automatic test_load_byte;
    run_txn(OPC_LOAD, F3_B, 32'h0000_0103, 32'h0, 5'd9, 32'h8011_2233, 1, -1);
    checks++;
    if (r_be !== 4'b1000 || r_load !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb: got be=%b ld=%h, want 1000 ffffff80", r_be, r_load);
    end
    run_txn(OPC_LOAD, F3_BU, 32'h0000_0103, 32'h0, 5'd9, 32'h8011_2233, 1, -1);
    exp_ld = 32'h0000_0080;
    checks++;
    if (r_be !== 4'b1000 || r_load !== exp_ld) begin
      errors++; $display("FAIL lbu: got be=%b ld=%h, want 1000 00000080", r_be, r_load);
    end
  endtask

  task automatic test_store_half;
    run_txn(OPC_STORE, F3_H, 32'h0000_0202, 32'h1234_ABCD, 5'd3, 32'h0, 1, -1);
    checks++;
    if (r_we !== 1'b1 || r_be !== 4'b1100 || r_wdata !== 32'hABCD_ABCD || r_addr !== 16'h0200) begin
      errors++;
      $display("FAIL sh_bus: got we=%b be=%b wdata=%h addr=%h, want 1 1100 abcdabcd 0200",
               r_we, r_be, r_wdata, r_addr);
    end
    checks++;
    if (r_wb_en !== 1'b0 || r_err !== 1'b0 || r_load !== exp_ld) begin
      errors++;
      $display("FAIL sh_result: got wb_en=%b err=%b ld=%h, want 0 0 %h", r_wb_en, r_err, r_load, exp_ld);
    end
  endtask

  task automatic test_long_ack;
    run_txn(OPC_LOAD, F3_H, 32'h0000_0306, 32'h0, 5'd12, 32'h9abc_1234, 10, 5);
    exp_ld = 32'hFFFF_9ABC;
    checks++;
    if (r_req_cycles !== 10 || r_stable !== 1'b1) begin
      errors++; $display("FAIL long_ack_hold: got req_cycles=%0d stable=%b, want 10 1", r_req_cycles, r_stable);
    end
    checks++;
    if (r_done_cyc !== 12 || r_extra_done !== 0 || r_extra_req !== 0) begin
      errors++;
      $display("FAIL long_ack_done: got done_cyc=%0d extra_done=%0d extra_req=%0d, want 12 0 0",
               r_done_cyc, r_extra_done, r_extra_req);
    end
    checks++;
    if (r_load !== exp_ld) begin errors++; $display("FAIL long_ack_ld: got %h want %h", r_load, exp_ld); end
  endtask

  task automatic test_timeout;
    run_txn(OPC_LOAD, F3_W, 32'h0000_0400, 32'h0, 5'd4, 32'h0, 0, -1);
    checks++;
    if (r_req_first !== 1 || r_done_cyc - r_req_first !== 256) begin
      errors++;
      $display("FAIL timeout_latency: got req_first=%0d done_cyc=%0d, want 1 257", r_req_first, r_done_cyc);
    end
    checks++;
    if (r_err !== 1'b1 || r_wb_en !== 1'b0 || r_load !== exp_ld) begin
      errors++;
      $display("FAIL timeout_result: got err=%b wb_en=%b ld=%h, want 1 0 %h", r_err, r_wb_en, r_load, exp_ld);
    end
  endtask

  task automatic test_misalign;
    run_txn(OPC_LOAD, F3_W, 32'h0000_0101, 32'h0, 5'd6, 32'h5566_7788, 1, -1);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (r_req_cycles !== 0 || r_done_cyc !== 2) begin
      errors++; $display("FAIL mis_trap_flow: got req_cycles=%0d done_cyc=%0d, want 0 2", r_req_cycles, r_done_cyc);
    end
    checks++;
    if (r_err !== 1'b1 || r_mis !== 1'b1 || r_wb_en !== 1'b0) begin
      errors++; $display("FAIL mis_trap_flags: got err=%b mis=%b wb_en=%b, want 1 1 0", r_err, r_mis, r_wb_en);
    end
`else
    exp_ld = 32'h5566_7788;
    checks++;
    if (r_addr !== 16'h0100 || r_be !== 4'b1111) begin
      errors++; $display("FAIL mis_force: got addr=%h be=%b, want 0100 1111", r_addr, r_be);
    end
    checks++;
    if (r_err !== 1'b0 || r_load !== exp_ld) begin
      errors++; $display("FAIL mis_force_ld: got err=%b ld=%h, want 0 %h", r_err, r_load, exp_ld);
    end
`endif
  endtask

  task automatic test_illegal;
    run_txn(OPC_LOAD, 3'b011, 32'h0000_0500, 32'h0, 5'd8, 32'h0, 1, -1);
    checks++;
    if (r_req_cycles !== 0 || r_done_cyc !== 2 || r_err !== 1'b1 || r_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL illegal_f3: got req_cycles=%0d done_cyc=%0d err=%b wb_en=%b, want 0 2 1 0",
               r_req_cycles, r_done_cyc, r_err, r_wb_en);
    end
  endtask

  task automatic test_bad_opcode;
    bit seen = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = 7'b0110011; funct3 = F3_W; addr = 32'h0000_0600;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done || mem_if.mem_req) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL bad_opcode: activity=%b want 0", seen); end
  endtask

  task automatic test_random;
    logic [2:0] legal_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    for (int n = 0; n < 40; n++) begin
      bit          st, ill, mis, trap;
      logic [2:0]  f3;
      logic [31:0] a, sd, rdat, ewd, eld;
      logic [3:0]  ebe;
      logic [4:0]  rdv;
      int          d, edone;
      st   = 1'($urandom_range(0, 1));
      f3   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      a    = $urandom; sd = $urandom; rdat = $urandom;
      rdv  = 5'($urandom_range(0, 31));
      d    = $urandom_range(1, 4);
      model(st, f3, a, sd, rdat, ill, mis, ebe, ewd, eld);
`ifdef LSU_MISALIGN_TRAP_EN
      trap = ill || mis;
`else
      trap = ill;
`endif
      edone = trap ? 2 : d + 2;
      run_txn(st ? OPC_STORE : OPC_LOAD, f3, a, sd, rdv, rdat, d, $urandom_range(1, 2));
      if (!st && !trap) exp_ld = eld;
      checks++;
      if (r_done_cyc !== edone || r_err !== trap) begin
        errors++;
        $display("FAIL rnd%0d_flow: st=%b f3=%b a=%h got done_cyc=%0d err=%b, want %0d %b",
                 n, st, f3, a, r_done_cyc, r_err, edone, trap);
      end
      checks++;
      if (r_wb_en !== (!st && !trap && rdv != 0) || r_wb_rd !== rdv || r_load !== exp_ld) begin
        errors++;
        $display("FAIL rnd%0d_wb: got wb_en=%b wb_rd=%0d ld=%h, want %b %0d %h",
                 n, r_wb_en, r_wb_rd, r_load, (!st && !trap && rdv != 0), rdv, exp_ld);
      end
      checks++;
      if (r_stray || r_extra_done != 0 || r_extra_req != 0) begin
        errors++;
        $display("FAIL rnd%0d_extra: got stray_err=%b extra_done=%0d extra_req=%0d, want 0 0 0",
                 n, r_stray, r_extra_done, r_extra_req);
      end
      checks++;
      if (trap) begin
        if (r_req_cycles !== 0) begin
          errors++; $display("FAIL rnd%0d_noreq: got req_cycles=%0d want 0", n, r_req_cycles);
        end
      end else if (r_req_cycles !== d || !r_stable || r_addr !== (a[15:0] & 16'hFFFC) ||
                   r_be !== ebe || r_we !== st || (st && r_wdata !== ewd)) begin
        errors++;
        $display("FAIL rnd%0d_bus: got req=%0d stable=%b addr=%h be=%b we=%b wd=%h, want %0d 1 %h %b %b %h",
                 n, r_req_cycles, r_stable, r_addr, r_be, r_we, r_wdata,
                 d, a[15:0] & 16'hFFFC, ebe, st, ewd);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      checks++;
      if (r_mis !== mis) begin errors++; $display("FAIL rnd%0d_mis: got %b want %b", n, r_mis, mis); end
`endif
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = OPC_LOAD; funct3 = F3_W; addr = 32'h0000_0700; rd = 5'd2;
    mem_if.mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_if.mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: mem_req=%b want 1", mem_if.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_if.mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got mem_req=%b busy=%b, want 0 0", mem_if.mem_req, busy);
    end
    exp_ld = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || mem_if.mem_req) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || load_data !== exp_ld) begin
      errors++; $display("FAIL rst_mid_after: activity=%b ld=%h, want 0 %h", seen, load_data, exp_ld);
    end
  endtask

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_load_word;
    test_load_byte;
    test_store_half;
    test_long_ack;
    test_misalign;
    test_illegal;
    test_bad_opcode;
    test_random;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit on the consumer side of the execute stage's address/result path.
- Takes an effective address, store data and the LOAD/STORE funct3 for one instruction.
- Runs one word-wide req/ack transaction on the data-memory port.
- Returns sign/zero-extended load data with a write-back destination, or completes a store with byte enables.

Parameters:
- ADDR_W, 16: width of mem_addr; byte address, lower ADDR_W bits of addr.
- TIMEOUT, 255: max cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; ignored while busy=1
- opcode  in  7  7'b0000011 LOAD or 7'b0100011 STORE; any other value is ignored
- funct3  in  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  in  32  effective byte address
- store_data  in  32  rs2 value; low bytes are used for sb/sh
- rd  in  5  load destination register
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done on timeout, illegal funct3, or misalign (see macro)
- wb_en  out  1  valid with done; high only for a successful load with rd!=0
- wb_rd  out  5  captured rd
- load_data  out  32  extended load result; held until the next done
- mem_req  out  1  memory request
- mem_we  out  1  1=store
- mem_addr  out  ADDR_W  word-aligned address: addr[ADDR_W-1:2],2'b00
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data replicated into the enabled lanes
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  memory completion; sampled only while mem_req=1

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-transaction drops mem_req asynchronously and no done is issued.
- FSM states IDLE, REQ, RESP.
- IDLE, on start with opcode LOAD/STORE and legal funct3:
  - Register opcode, funct3, addr[1:0], store_data and rd.
  - Drive mem_addr, mem_be and mem_wdata.
  - Go to REQ on the next edge.
- IDLE, on start with illegal funct3 (011, 110, 111; and 100/101 for STORE): go straight to RESP with err=1; no memory access.
- IDLE, on start with any other opcode: ignored.
- REQ:
  - mem_req=1; mem_addr, mem_be, mem_we and mem_wdata are held stable.
  - The wait counter increments each cycle.
  - On mem_ack go to RESP, capturing extended mem_rdata for loads.
  - If the counter reaches TIMEOUT before ack, go to RESP with err=1; load_data is unchanged and wb_en=0.
- RESP: done=1 for one cycle, then IDLE.
- Latency with single-cycle ack: start at cycle 0, mem_req at cycle 1, done at cycle 3 (ack sampled at cycle 1 moves to RESP at 2; done registered at 3). Minimum start-to-start spacing is 4 cycles.
- Byte enables:
  - b/bu: 4'b0001<<addr[1:0]
  - h/hu: 4'b0011<<{addr[1],1'b0}
  - w: 4'b1111
- Write data: sb replicates byte 4x; sh replicates half 2x.
- Load extraction:
  - Select the lane by addr[1:0].
  - lb/lh sign-extend bit 7/15; lbu/lhu zero-extend.
- start while busy: dropped, no queueing.
- mem_ack while mem_req=0: ignored.
- Counter saturates; no wrap-around.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, performs no memory access.
  - FSM goes IDLE->RESP; done=1, err=1, wb_en=0.
  - Extra output misalign, 1 bit, pulses with done.
- Undefined:
  - The offending low address bits are forced to the natural alignment: half clears addr[0], word clears addr[1:0].
  - The access proceeds normally and err is never raised for alignment.
  - The misalign port is absent.

Decomposition:
- Shared package rv_pkg holds:
  - Opcode constants LOAD/STORE.
  - funct3 size encodings.
  - The lsu_state_t enum (IDLE, REQ, RESP).
- One sub-module, lsu_align, is natural:
  - Combinational.
  - Inputs funct3, addr[1:0], store_data, mem_rdata.
  - Outputs mem_be, mem_wdata, extended load value and misalign flag.

Test Plan:
- lw at addr 0x0000_0104, memory returns 0xDEADBEEF with 1-cycle ack, rd=5 -> mem_addr=0x0104, be=1111, done at cycle 3, load_data=0xDEADBEEF, wb_en=1, wb_rd=5.
- lb at 0x103, rdata=0x80112233 -> be=1000, load_data=0xFFFFFF80. lbu at the same address -> 0x00000080.
- sh at 0x202, store_data=0x1234ABCD -> mem_we=1, be=1100, mem_wdata=0xABCDABCD, wb_en=0.
- Ack delayed 10 cycles -> mem_req and mem_addr stable for all 10 cycles; a second start during busy is ignored and produces exactly one done.
- No ack, TIMEOUT=255 -> done+err 256 cycles after mem_req rises, wb_en=0, load_data unchanged. Also assert rst_n low mid-REQ -> mem_req=0 immediately, no done.
- With LSU_MISALIGN_TRAP_EN: lw at 0x101 -> mem_req never asserted, done+err+misalign in the same cycle. Without the macro: mem_addr=0x100, be=1111.
